// File: rtl/phase_shift_gen_ddr.sv
`default_nettype none
// ============================================================================
// Module      : phase_shift_gen_ddr
// Description : Regenerates an 8-sample-per-clock reference square wave
//               delayed by a programmable number of subsamples. Edges are
//               timestamped into a small event FIFO and replayed when due.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_shift_gen_ddr #(
    parameter int POSITION_BITS   = 14,
    parameter int DELAY_BITS      = 10,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CE,
    input  logic [7:0]            IN_BITS,
    input  logic [DELAY_BITS-1:0] DELAY,
    output logic [7:0]            OUT_BITS,
    output logic                  FIFO_EMPTY,
    output logic                  OVERFLOW
);

    localparam int c_cnt_bits   = POSITION_BITS - 3;
    localparam int c_depth      = 1 << FIFO_DEPTH_BITS;
    localparam int c_entry_bits = POSITION_BITS + 1;

    localparam logic [POSITION_BITS-1:0]   c_pipe_offset = 16;
    localparam logic [c_cnt_bits-1:0]      c_cnt_one     = 1;
    localparam logic [FIFO_DEPTH_BITS:0]   c_ptr_one     = 1;

    logic [c_cnt_bits-1:0]    r_cnt;
    logic                     r_prev;
    logic                     r_cur;
    logic                     r_ev_valid;
    logic                     r_ev_level;
    logic [POSITION_BITS-1:0] r_ev_due;
    logic [FIFO_DEPTH_BITS:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS:0] r_rd_ptr;
    logic [c_entry_bits-1:0]  r_mem [c_depth];
    logic [7:0]               r_out;
    logic                     r_ovf;

    logic                     w_final;
    logic                     w_edge;
    logic [2:0]               w_idx;
    logic                     w_run;
    logic [POSITION_BITS-1:0] w_due;
    logic                     w_empty;
    logic                     w_full;
    logic [c_entry_bits-1:0]  w_head;
    logic                     w_head_level;
    logic [POSITION_BITS-1:0] w_head_due;
    logic [c_cnt_bits-1:0]    w_diff;
    logic                     w_on_time;
    logic                     w_late;
    logic                     w_pop;
    logic                     w_push_ok;
    logic [7:0]               w_out;

    // Edge detect: only the word's final level matters; the index marks where
    // the trailing run of that level begins.
    assign w_final = IN_BITS[7];
    assign w_edge  = (w_final != r_prev);

    always_comb begin
        w_idx = 3'd7;
        w_run = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            if (w_run && (IN_BITS[i] == w_final)) begin
                w_idx = 3'(i);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_due = {r_cnt, w_idx} + POSITION_BITS'(DELAY) + c_pipe_offset;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_DEPTH_BITS-1:0] == r_rd_ptr[FIFO_DEPTH_BITS-1:0]) &&
                     (r_wr_ptr[FIFO_DEPTH_BITS] != r_rd_ptr[FIFO_DEPTH_BITS]);

    assign w_head       = r_mem[r_rd_ptr[FIFO_DEPTH_BITS-1:0]];
    assign w_head_level = w_head[POSITION_BITS];
    assign w_head_due   = w_head[POSITION_BITS-1:0];

    // Modular distance to the due cycle; upper half of the window means past.
    assign w_diff    = w_head_due[POSITION_BITS-1:3] - r_cnt;
    assign w_on_time = !w_empty && (w_diff == '0);
    assign w_late    = !w_empty && w_diff[c_cnt_bits-1];
    assign w_pop     = w_on_time || w_late;
    assign w_push_ok = r_ev_valid && (!w_full || w_pop);

    always_comb begin
        w_out = {8{r_cur}};
        if (w_on_time) begin
            for (int i = 0; i < 8; i++) begin
                w_out[i] = (3'(i) < w_head_due[2:0]) ? r_cur : w_head_level;
            end
        end else if (w_late) begin
            w_out = {8{w_head_level}};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_prev     <= 1'b0;
            r_cur      <= 1'b0;
            r_ev_valid <= 1'b0;
            r_ev_level <= 1'b0;
            r_ev_due   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out      <= '0;
            r_ovf      <= 1'b0;
        end else if (CE) begin
            r_cnt      <= r_cnt + c_cnt_one;
            r_prev     <= w_final;
            r_ev_valid <= w_edge;
            r_ev_level <= w_final;
            r_ev_due   <= w_due;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end else if (r_ev_valid) begin
                r_ovf <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_cur    <= w_head_level;
            end
            r_out <= w_out;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge CLK) begin
        if (CE && w_push_ok) begin
            r_mem[r_wr_ptr[FIFO_DEPTH_BITS-1:0]] <= {r_ev_level, r_ev_due};
        end
    end

    assign OUT_BITS   = r_out;
    assign FIFO_EMPTY = w_empty;
    assign OVERFLOW   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_phase_shift_gen_ddr.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_shift_gen_ddr
// Description : Directed self-checking bench for phase_shift_gen_ddr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_shift_gen_ddr;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [7:0] in_bits;
    logic [9:0] delay;
    logic [7:0] out_bits;
    logic       fifo_empty;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;
    int tb_cnt  = 0;

    always #5 clk = ~clk;

    phase_shift_gen_ddr #(
        .POSITION_BITS   (14),
        .DELAY_BITS      (10),
        .FIFO_DEPTH_BITS (3)
    ) u_dut (
        .CLK        (clk),
        .RESET      (rst),
        .CE         (ce),
        .IN_BITS    (in_bits),
        .DELAY      (delay),
        .OUT_BITS   (out_bits),
        .FIFO_EMPTY (fifo_empty),
        .OVERFLOW   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        if (ce) tb_cnt++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic settle(input logic [7:0] w);
        in_bits = w;
        delay   = 10'd0;
        ticks(6);
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; in_bits = 8'h00; delay = 10'd0;
        #12;
        n_total++; if (out_bits !== 8'h00) $display("FAIL reset_out got %h exp 00", out_bits); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", fifo_empty); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0; tb_cnt = 0;
        ticks(3);
        n_total++; if (out_bits !== 8'h00) $display("FAIL idle_out got %h exp 00", out_bits); else n_pass++;
    endtask

    task automatic test_delay0();
        settle(8'h00);
        in_bits = 8'hF0; tick();
        in_bits = 8'hFF; tick();
        n_total++; if (out_bits !== 8'h00) $display("FAIL d0_k2 got %h exp 00", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hF0) $display("FAIL d0_k3 got %h exp F0", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hFF) $display("FAIL d0_k4 got %h exp FF", out_bits); else n_pass++;
    endtask

    task automatic test_delay5(input bit wrap);
        settle(8'h00);
        if (wrap) begin
            while ((tb_cnt % 2048) != 2046) tick();
        end
        delay = 10'd5;
        in_bits = 8'hF0; tick();
        in_bits = 8'hFF; tick(); tick();
        n_total++; if (out_bits !== 8'h00) $display("FAIL d5_k2 wrap=%0d got %h exp 00", wrap, out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hFE) $display("FAIL d5_k3 wrap=%0d got %h exp FE", wrap, out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hFF) $display("FAIL d5_k4 wrap=%0d got %h exp FF", wrap, out_bits); else n_pass++;
    endtask

    task automatic test_glitch();
        settle(8'h00);
        in_bits = 8'h18; tick();
        in_bits = 8'h00; tick();
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL glitch_empty got %b exp 1", fifo_empty); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'h00) $display("FAIL glitch_out got %h exp 00", out_bits); else n_pass++;
        settle(8'hFF);
        n_total++; if (out_bits !== 8'hFF) $display("FAIL rise_idx0 got %h exp FF", out_bits); else n_pass++;
        in_bits = 8'h0F; tick();
        in_bits = 8'h00; tick(); tick();
        n_total++; if (out_bits !== 8'h0F) $display("FAIL fall_idx4 got %h exp 0F", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'h00) $display("FAIL fall_after got %h exp 00", out_bits); else n_pass++;
    endtask

    task automatic test_overflow();
        settle(8'h00);
        delay = 10'd200;
        for (int j = 0; j < 9; j++) begin
            in_bits = (j % 2 == 0) ? 8'hF0 : 8'h0F;
            tick();
        end
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %b exp 0", overflow); else n_pass++;
        in_bits = 8'hFF; tick();
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else n_pass++;
        ticks(17);
        n_total++; if (out_bits !== 8'h00) $display("FAIL ovf_pre got %h exp 00", out_bits); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_total++;
            if (out_bits !== ((j % 2 == 0) ? 8'hF0 : 8'h0F))
                $display("FAIL ovf_replay%0d got %h exp %h", j, out_bits, (j % 2 == 0) ? 8'hF0 : 8'h0F);
            else n_pass++;
        end
        tick();
        n_total++; if (out_bits !== 8'h00) $display("FAIL ovf_post got %h exp 00", out_bits); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL ovf_drained got %b exp 1", fifo_empty); else n_pass++;
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow); else n_pass++;
    endtask

    task automatic test_late();
        settle(8'h00);
        delay = 10'd400;
        in_bits = 8'hF0; tick();
        in_bits = 8'h0F; tick();
        in_bits = 8'hF0; tick();
        delay = 10'd0;
        in_bits = 8'h0F; tick();
        in_bits = 8'h00;
        ticks(48);
        n_total++; if (out_bits !== 8'h00) $display("FAIL late_pre got %h exp 00", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hF0) $display("FAIL late_q0 got %h exp F0", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'h0F) $display("FAIL late_q1 got %h exp 0F", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hF0) $display("FAIL late_q2 got %h exp F0", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'h00) $display("FAIL late_q3 got %h exp 00", out_bits); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL late_empty got %b exp 1", fifo_empty); else n_pass++;
    endtask

    task automatic test_ce();
        settle(8'h00);
        delay = 10'd40;
        in_bits = 8'hF0; tick();
        in_bits = 8'hFF; ticks(3);
        ce = 1'b0; in_bits = 8'h00;
        ticks(10);
        n_total++; if (out_bits !== 8'h00) $display("FAIL ce_frozen got %h exp 00", out_bits); else n_pass++;
        n_total++; if (fifo_empty !== 1'b0) $display("FAIL ce_queued got %b exp 0", fifo_empty); else n_pass++;
        ce = 1'b1; in_bits = 8'hFF;
        ticks(3);
        n_total++; if (out_bits !== 8'h00) $display("FAIL ce_resume3 got %h exp 00", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hF0) $display("FAIL ce_resume4 got %h exp F0", out_bits); else n_pass++;
        tick();
        n_total++; if (out_bits !== 8'hFF) $display("FAIL ce_resume5 got %h exp FF", out_bits); else n_pass++;
    endtask

    task automatic test_reset_mid();
        settle(8'hFF);
        delay = 10'd400;
        in_bits = 8'h0F; tick();
        in_bits = 8'hF0; tick();
        in_bits = 8'h0F; tick();
        in_bits = 8'hF0; tick();
        in_bits = 8'hFF; ticks(2);
        n_total++; if (fifo_empty !== 1'b0) $display("FAIL rm_queued got %b exp 0", fifo_empty); else n_pass++;
        n_total++; if (out_bits !== 8'hFF) $display("FAIL rm_high got %h exp FF", out_bits); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (out_bits !== 8'h00) $display("FAIL rm_out got %h exp 00", out_bits); else n_pass++;
        n_total++; if (fifo_empty !== 1'b1) $display("FAIL rm_empty got %b exp 1", fifo_empty); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL rm_ovf got %b exp 0", overflow); else n_pass++;
        in_bits = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0; tb_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_total++; if (out_bits !== 8'h00) $display("FAIL rm_stale%0d got %h exp 00", i, out_bits); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; in_bits = 8'h00; delay = 10'd0;
        test_reset();
        test_delay0();
        test_delay5(1'b0);
        test_delay5(1'b1);
        test_glitch();
        test_overflow();
        test_late();
        test_ce();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
